// File: rtl/ysyx_22050243_mem_pkg.sv
// Shared types for the instruction-fetch / load-store memory arbiter.
// Holds the FSM state encoding, the requester (owner) encoding and default widths.
package ysyx_22050243_mem_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int MASK_W     = 8;
  localparam int INST_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Owner bit doubles as the index into the arbiter request/grant vectors.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Instructions are 32 bits inside a 64-bit beat; address bit 2 picks the half.
  function automatic logic [INST_W-1:0] sel_inst(input logic [63:0] rdata,
                                                 input logic        hi);
    return hi ? rdata[63:32] : rdata[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22050243_rr_arb2.sv
// Two-way round-robin arbiter: index 0 is fetch, index 1 is load/store.
// On a tie the requester that was not granted last wins; the last-grant bit resets to LSU.
module ysyx_22050243_rr_arb2
  import ysyx_22050243_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = req;
    last_d = last_q;
    if (req == 2'b11) begin
      gnt = (last_q == OWN_LS) ? 2'b01 : 2'b10;
    end
    if (advance && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_LS;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ysyx_22050243_mem_arb.sv
// Shares one memory port between instruction fetch and the LSU, one transaction at a time.
// Valid/ready: a request transfers on a cycle where both valid and ready are high; responses are single-cycle pulses.
module ysyx_22050243_mem_arb
  import ysyx_22050243_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_inst,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [7:0]        ls_wmask,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic [1:0]        dbg_state
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic              if_rv_q, if_rv_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic              ls_rv_q, ls_rv_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       arb_adv;

  // Requests are only offered to the arbiter while idle and out of reset,
  // so no ready can leak out during reset or an outstanding transaction.
  assign arb_req = (state_q == IDLE && rst_n) ? {ls_req_valid, if_req_valid} : 2'b00;
  assign arb_adv = (arb_gnt != 2'b00);

  ysyx_22050243_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (arb_adv),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    if_rv_d       = 1'b0;
    if_inst_d     = if_inst_q;
    ls_rv_d       = 1'b0;
    ls_rdata_d    = ls_rdata_q;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_gnt[OWN_IF]) begin
          if_req_ready = 1'b1;
          owner_d      = OWN_IF;
          we_d         = 1'b0;
          addr_d       = if_addr;
          wdata_d      = '0;
          wmask_d      = '0;
          state_d      = REQ;
        end else if (arb_gnt[OWN_LS]) begin
          ls_req_ready = 1'b1;
          owner_d      = OWN_LS;
          we_d         = ls_we;
          addr_d       = ls_addr;
          wdata_d      = ls_wdata;
          wmask_d      = ls_wmask;
          state_d      = REQ;
        end
      end

      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
          if (owner_q == OWN_IF) begin
            if_rv_d   = 1'b1;
            if_inst_d = sel_inst(mem_resp_rdata[63:0], addr_q[2]);
          end else begin
            ls_rv_d    = 1'b1;
            ls_rdata_d = we_q ? '0 : mem_resp_rdata;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      if_rv_q    <= 1'b0;
      if_inst_q  <= '0;
      ls_rv_q    <= 1'b0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      if_rv_q    <= if_rv_d;
      if_inst_q  <= if_inst_d;
      ls_rv_q    <= ls_rv_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign if_resp_valid = if_rv_q;
  assign if_resp_inst  = if_inst_q;
  assign ls_resp_valid = ls_rv_q;
  assign ls_resp_rdata = ls_rdata_q;
  assign dbg_state     = state_q;

endmodule
